// File: rtl/lcd_seq_arb.sv
// Two-requester round-robin arbiter feeding a 9-bit serial frame ({D, RS}, RS first) to an LCD
// serial slave, followed by a busy wait that is long for clear/home commands.
module lcd_seq_arb #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SHORT_WAIT = 2000,
  parameter int unsigned LONG_WAIT  = 80000
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       RS0,
  input  logic       RS1,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       SSEL,
  output logic       SCK,
  output logic       MOSI,
  output logic       BUSY
);

  localparam int unsigned MAX_WAIT = (LONG_WAIT > SHORT_WAIT) ? LONG_WAIT : SHORT_WAIT;
  localparam int unsigned WW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  localparam logic [7:0]    PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [WW-1:0] SHORT_LAST = WW'(SHORT_WAIT - 1);
  localparam logic [WW-1:0] LONG_LAST  = WW'(LONG_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    phase_q, phase_d;
  logic [3:0]    bitCnt_q, bitCnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [8:0]    shift_q, shift_d;
  logic          longWait_q, longWait_d;
  logic          lastGrant_q, lastGrant_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          ssel_q, ssel_d;
  logic          sck_q, sck_d;
  logic          busy_q, busy_d;

  logic          grantOne;
  logic          rsSel;
  logic [7:0]    dSel;
  logic          phaseDone;
  logic [WW-1:0] waitLast;

  // Requester 1 wins when alone, or in contention when requester 0 was served last.
  assign grantOne  = REQ1 & (~REQ0 | ~lastGrant_q);
  assign rsSel     = grantOne ? RS1 : RS0;
  assign dSel      = grantOne ? D1 : D0;
  assign phaseDone = (phase_q == PHASE_LAST);
  assign waitLast  = longWait_q ? LONG_LAST : SHORT_LAST;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitCnt_d    = bitCnt_q;
    wait_d      = wait_q;
    shift_d     = shift_q;
    longWait_d  = longWait_q;
    lastGrant_d = lastGrant_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    ssel_d      = ssel_q;
    sck_d       = sck_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          state_d     = SETUP;
          shift_d     = {dSel, rsSel};
          longWait_d  = ~rsSel && (dSel <= 8'h03);
          lastGrant_d = grantOne;
          ack0_d      = ~grantOne;
          ack1_d      = grantOne;
          ssel_d      = 1'b0;
          sck_d       = 1'b0;
          busy_d      = 1'b1;
          phase_d     = '0;
          bitCnt_d    = '0;
        end
      end

      SETUP: begin
        if (phaseDone) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      // The shift word drops its LSB only on the falling SCK edge, so MOSI is stable while high.
      SCK_HI: begin
        if (phaseDone) begin
          sck_d   = 1'b0;
          phase_d = '0;
          if (bitCnt_q == 4'd8) begin
            state_d = HOLD;
          end else begin
            state_d  = SCK_LO;
            bitCnt_d = bitCnt_q + 4'd1;
            shift_d  = {1'b0, shift_q[8:1]};
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      SCK_LO: begin
        if (phaseDone) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      HOLD: begin
        if (phaseDone) begin
          state_d = WAIT;
          ssel_d  = 1'b1;
          shift_d = '0;
          phase_d = '0;
          wait_d  = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      WAIT: begin
        if (wait_q == waitLast) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ssel_d  = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
        shift_d = '0;
      end
    endcase
  end

  // Reset abandons any frame or wait in progress; the pointer favours requester 0 next.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bitCnt_q    <= '0;
      wait_q      <= '0;
      shift_q     <= '0;
      longWait_q  <= 1'b0;
      lastGrant_q <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      ssel_q      <= 1'b1;
      sck_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitCnt_q    <= bitCnt_d;
      wait_q      <= wait_d;
      shift_q     <= shift_d;
      longWait_q  <= longWait_d;
      lastGrant_q <= lastGrant_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      ssel_q      <= ssel_d;
      sck_q       <= sck_d;
      busy_q      <= busy_d;
    end
  end

  assign ACK0 = ack0_q;
  assign ACK1 = ack1_q;
  assign SSEL = ssel_q;
  assign SCK  = sck_q;
  assign MOSI = shift_q[0];
  assign BUSY = busy_q;

endmodule

// File: tb/tb_lcd_seq_arb.sv
// Directed bench for lcd_seq_arb with an SCK/SSEL serial slave model recovering each frame.
module tb_lcd_seq_arb;

  localparam int CLK_DIV    = 4;
  localparam int SHORT_WAIT = 20;
  localparam int LONG_WAIT  = 60;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic       RS0 = 1'b0, RS1 = 1'b0;
  logic [7:0] D0 = 8'h00, D1 = 8'h00;
  logic       ACK0, ACK1, SSEL, SCK, MOSI, BUSY;

  int vectors = 0;
  int miscompares = 0;

  lcd_seq_arb #(
    .CLK_DIV   (CLK_DIV),
    .SHORT_WAIT(SHORT_WAIT),
    .LONG_WAIT (LONG_WAIT)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .REQ0(REQ0),
    .REQ1(REQ1),
    .RS0 (RS0),
    .RS1 (RS1),
    .D0  (D0),
    .D1  (D1),
    .ACK0(ACK0),
    .ACK1(ACK1),
    .SSEL(SSEL),
    .SCK (SCK),
    .MOSI(MOSI),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Monitors: cycle index, serial slave, frame timing and grant history.
  int         cyc = 0;
  logic [8:0] rxWord = '0;
  int         rxBits = 0;
  int         lowCnt = 0;
  int         sselRiseCyc = 0;
  int         busyFallCyc = 0;
  int         ack1RiseCyc = 0;
  int         bothAck = 0;
  logic [8:0] frames[$];
  int         frameBits[$];
  int         grantQ[$];

  always @(posedge CLK) begin
    cyc++;
    if (SSEL === 1'b0) lowCnt++;
  end

  always @(negedge SSEL) begin
    rxBits = 0;
    rxWord = '0;
    lowCnt = 0;
  end

  always @(posedge SCK) begin
    if (SSEL === 1'b0) begin
      rxWord = {MOSI, rxWord[8:1]};
      rxBits++;
    end
  end

  always @(posedge SSEL) begin
    frames.push_back(rxWord);
    frameBits.push_back(rxBits);
    sselRiseCyc = cyc;
  end

  always @(negedge BUSY) busyFallCyc = cyc;
  always @(posedge ACK1) ack1RiseCyc = cyc;

  always @(negedge CLK) begin
    if (ACK0 === 1'b1 && ACK1 === 1'b1) bothAck++;
    if (ACK0 === 1'b1) grantQ.push_back(0);
    if (ACK1 === 1'b1) grantQ.push_back(1);
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input logic rs, input logic [7:0] d);
    if (who == 0) begin
      RS0 = rs; D0 = d; REQ0 = 1'b1;
    end else begin
      RS1 = rs; D1 = d; REQ1 = 1'b1;
    end
  endtask

  task automatic waitAck(input int who, input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLK);
      if (((who == 0) ? ACK0 : ACK1) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic waitIdle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  // Recovered frame and post-frame wait against the hand model {D, RS}, long for RS=0 && D<=3.
  task automatic checkFrame(input string tag, input logic rs, input logic [7:0] d);
    int expWait;
    expWait = (!rs && d <= 8'h03) ? LONG_WAIT : SHORT_WAIT;
    checkOutput({tag, " frame count"}, frames.size(), 1);
    if (frames.size() > 0) begin
      checkOutput({tag, " rx word"}, {23'd0, frames.pop_front()}, {23'd0, d, rs});
      checkOutput({tag, " rx bits"}, frameBits.pop_front(), 9);
    end
    checkOutput({tag, " wait"}, busyFallCyc - sselRiseCyc, expWait);
    frames.delete();
    frameBits.delete();
  endtask

  task automatic runFrame(input string tag, input int who, input logic rs, input logic [7:0] d);
    int   lat;
    logic ok;
    applyStimulus(who, rs, d);
    waitAck(who, 16, lat);
    checkOutput({tag, " ack latency"}, lat, 1);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);
    checkOutput({tag, " ack width"}, {30'd0, ACK1, ACK0}, 0);
    waitIdle(ok);
    checkOutput({tag, " idle"}, {31'd0, ok}, 1);
    checkFrame(tag, rs, d);
  endtask

  initial begin
    int         lat;
    logic       ok;
    logic       rs;
    logic [7:0] d;
    int         who;
    logic [8:0] waitTab[4];

    $display("[TB] start");

    // Reset state.
    repeat (3) @(negedge CLK);
    checkOutput("rst SSEL", {31'd0, SSEL}, 1);
    checkOutput("rst SCK", {31'd0, SCK}, 0);
    checkOutput("rst MOSI", {31'd0, MOSI}, 0);
    checkOutput("rst ACK0", {31'd0, ACK0}, 0);
    checkOutput("rst ACK1", {31'd0, ACK1}, 0);
    checkOutput("rst BUSY", {31'd0, BUSY}, 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("idle BUSY", {31'd0, BUSY}, 0);

    // Data frame A5: first cycle after grant, then recovered bits and SSEL-low length.
    frames.delete();
    frameBits.delete();
    applyStimulus(0, 1'b1, 8'hA5);
    @(negedge CLK);
    checkOutput("a5 ACK0", {31'd0, ACK0}, 1);
    checkOutput("a5 ACK1", {31'd0, ACK1}, 0);
    checkOutput("a5 BUSY", {31'd0, BUSY}, 1);
    checkOutput("a5 SSEL", {31'd0, SSEL}, 0);
    checkOutput("a5 SCK", {31'd0, SCK}, 0);
    checkOutput("a5 MOSI", {31'd0, MOSI}, 1);
    REQ0 = 1'b0;
    @(negedge CLK);
    checkOutput("a5 ACK0 pulse", {31'd0, ACK0}, 0);
    waitIdle(ok);
    checkOutput("a5 idle", {31'd0, ok}, 1);
    checkOutput("a5 SSEL low", lowCnt, 76);
    checkOutput("a5 word", {23'd0, (frames.size() > 0) ? frames[0] : 9'h000}, 32'h14B);
    checkFrame("a5", 1'b1, 8'hA5);

    // Wait-length boundary: command 01/03 long, 04 short, data 00 short.
    waitTab = '{9'h002, 9'h006, 9'h008, 9'h001};
    for (int i = 0; i < 4; i++) begin
      runFrame($sformatf("wait%0d", i), 0, waitTab[i][0], waitTab[i][8:1]);
    end

    // Round-robin from reset with both requesters held.
    doReset();
    frames.delete();
    frameBits.delete();
    grantQ.delete();
    bothAck = 0;
    RS0 = 1'b1; D0 = 8'h3C;
    RS1 = 1'b0; D1 = 8'hC3;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    for (int i = 0; i < 2000 && grantQ.size() < 4; i++) @(negedge CLK);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    waitIdle(ok);
    checkOutput("rr idle", {31'd0, ok}, 1);
    checkOutput("rr grants", grantQ.size(), 4);
    if (grantQ.size() >= 4) begin
      checkOutput("rr g0", grantQ[0], 0);
      checkOutput("rr g1", grantQ[1], 1);
      checkOutput("rr g2", grantQ[2], 0);
      checkOutput("rr g3", grantQ[3], 1);
    end
    checkOutput("rr overlap", bothAck, 0);
    checkOutput("rr frames", frames.size(), 4);
    if (frames.size() >= 4) begin
      checkOutput("rr f0", {23'd0, frames[0]}, {23'd0, 8'h3C, 1'b1});
      checkOutput("rr f1", {23'd0, frames[1]}, {23'd0, 8'hC3, 1'b0});
      checkOutput("rr f2", {23'd0, frames[2]}, {23'd0, 8'h3C, 1'b1});
      checkOutput("rr f3", {23'd0, frames[3]}, {23'd0, 8'hC3, 1'b0});
    end
    frames.delete();
    frameBits.delete();

    // Reset during the 5th SCK high phase, then a fresh frame from requester 1.
    applyStimulus(0, 1'b1, 8'hFF);
    waitAck(0, 16, lat);
    checkOutput("mid ack", lat, 1);
    REQ0 = 1'b0;
    for (int i = 0; i < 200 && rxBits < 5; i++) @(negedge CLK);
    checkOutput("mid SCK high", {31'd0, SCK}, 1);
    #2 nRST = 1'b0;
    #1;
    checkOutput("mid SSEL", {31'd0, SSEL}, 1);
    checkOutput("mid SCK", {31'd0, SCK}, 0);
    checkOutput("mid BUSY", {31'd0, BUSY}, 0);
    checkOutput("mid MOSI", {31'd0, MOSI}, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("mid stays idle", {31'd0, BUSY}, 0);
    frames.delete();
    frameBits.delete();
    runFrame("fresh", 1, 1'b1, 8'h5A);

    // Request raised during WAIT is granted right after BUSY falls.
    applyStimulus(0, 1'b1, 8'h42);
    waitAck(0, 16, lat);
    checkOutput("pend ack0", lat, 1);
    REQ0 = 1'b0;
    for (int i = 0; i < 200 && SSEL !== 1'b1; i++) @(negedge CLK);
    checkOutput("pend in wait", {30'd0, SSEL, BUSY}, 3);
    applyStimulus(1, 1'b1, 8'h99);
    waitAck(1, 200, lat);
    checkOutput("pend ack1 found", {31'd0, lat > 0}, 1);
    checkOutput("pend ack1 timing", ack1RiseCyc - busyFallCyc, 1);
    REQ1 = 1'b0;
    checkFrame("pend first", 1'b1, 8'h42);
    waitIdle(ok);
    checkOutput("pend idle", {31'd0, ok}, 1);
    checkFrame("pend second", 1'b1, 8'h99);

    // Slave-model sweep over random frames.
    for (int i = 0; i < 256; i++) begin
      who = $urandom_range(0, 1);
      rs  = 1'($urandom_range(0, 1));
      d   = (i % 8 == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      runFrame($sformatf("rnd%0d", i), who, rs, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
